// File: rtl/dice_result_stabilizer.sv
// Frame-level temporal filter: confirms a stable dice color, hands it off over valid/ready,
// then waits for a white background before re-arming. Optional WAIT_CLEAR timeout: DICE_STAB_TIMEOUT_EN.
module dice_result_stabilizer #(
  parameter int STABLE_FRAMES  = 3,
  parameter int WHITE_FRAMES   = 2,
  parameter int TIMEOUT_FRAMES = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_enable,
  input  logic        frame_done,
  input  logic        color_valid,
  input  logic        white_detected,
  input  logic [1:0]  dominant_color,
  input  logic [15:0] color_confidence,
  input  logic        result_ready,
  output logic        dice_valid,
  output logic [1:0]  dice_color,
  output logic [15:0] dice_confidence,
  output logic        turn_end,
  output logic        timeout,
  output logic [1:0]  state
);

  // state      | meaning
  // ARMED      | idle, waiting for the first color frame of a turn
  // CONFIRM    | counting consecutive frames of the candidate color
  // HOLD       | result presented, waiting for the game FSM to accept
  // WAIT_CLEAR | waiting for consecutive white frames to end the turn
  typedef enum logic [1:0] {
    ST_ARMED      = 2'd0,
    ST_CONFIRM    = 2'd1,
    ST_HOLD       = 2'd2,
    ST_WAIT_CLEAR = 2'd3
  } state_t;

  localparam logic [7:0] LP_STABLE = 8'(STABLE_FRAMES);
  localparam logic [7:0] LP_WHITE  = 8'(WHITE_FRAMES);

  state_t      r_state;
  logic [1:0]  r_cand;
  logic [7:0]  r_cnt;
  logic [7:0]  r_wcnt;
  logic [15:0] r_minconf;
  logic        r_dice_valid;
  logic [1:0]  r_dice_color;
  logic [15:0] r_dice_conf;
  logic        r_turn_end;
  logic        r_timeout;

  logic        w_is_color;
  logic        w_is_white;
  logic [7:0]  w_cnt_inc;
  logic [7:0]  w_wcnt_inc;
  logic [15:0] w_min;
  logic        w_white_done;

  // A color report wins over a simultaneous white report.
  assign w_is_color   = frame_done && color_valid && (dominant_color != 2'b00);
  assign w_is_white   = frame_done && white_detected && !w_is_color;
  assign w_cnt_inc    = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
  assign w_wcnt_inc   = (r_wcnt == 8'hFF) ? 8'hFF : r_wcnt + 8'd1;
  assign w_min        = (color_confidence < r_minconf) ? color_confidence : r_minconf;
  assign w_white_done = w_is_white && (w_wcnt_inc == LP_WHITE);

`ifdef DICE_STAB_TIMEOUT_EN
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_FRAMES);
  logic [7:0] r_tcnt;
  logic [7:0] w_tcnt_inc;
  assign w_tcnt_inc = (r_tcnt == 8'hFF) ? 8'hFF : r_tcnt + 8'd1;
`else
  logic [7:0] w_unused_timeout_frames;
  assign w_unused_timeout_frames = 8'(TIMEOUT_FRAMES);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_ARMED;
      r_cand       <= 2'b00;
      r_cnt        <= 8'd0;
      r_wcnt       <= 8'd0;
      r_minconf    <= 16'd0;
      r_dice_valid <= 1'b0;
      r_dice_color <= 2'b00;
      r_dice_conf  <= 16'd0;
      r_turn_end   <= 1'b0;
      r_timeout    <= 1'b0;
`ifdef DICE_STAB_TIMEOUT_EN
      r_tcnt       <= 8'd0;
`endif
    end else begin
      r_turn_end <= 1'b0;
      r_timeout  <= 1'b0;
      if (!game_enable) begin
        r_state      <= ST_ARMED;
        r_cnt        <= 8'd0;
        r_wcnt       <= 8'd0;
        r_dice_valid <= 1'b0;
`ifdef DICE_STAB_TIMEOUT_EN
        r_tcnt       <= 8'd0;
`endif
      end else begin
        case (r_state)
          ST_ARMED: begin
            if (w_is_color) begin
              r_cand    <= dominant_color;
              r_cnt     <= 8'd1;
              r_minconf <= color_confidence;
              if (LP_STABLE == 8'd1) begin
                r_state      <= ST_HOLD;
                r_dice_valid <= 1'b1;
                r_dice_color <= dominant_color;
                r_dice_conf  <= color_confidence;
              end else begin
                r_state <= ST_CONFIRM;
              end
            end
          end
          ST_CONFIRM: begin
            if (w_is_color) begin
              if (dominant_color == r_cand) begin
                r_cnt     <= w_cnt_inc;
                r_minconf <= w_min;
                if (w_cnt_inc == LP_STABLE) begin
                  r_state      <= ST_HOLD;
                  r_dice_valid <= 1'b1;
                  r_dice_color <= r_cand;
                  r_dice_conf  <= w_min;
                end
              end else begin
                r_cand    <= dominant_color;
                r_cnt     <= 8'd1;
                r_minconf <= color_confidence;
              end
            end else if (w_is_white) begin
              r_state <= ST_ARMED;
              r_cnt   <= 8'd0;
            end
          end
          ST_HOLD: begin
            if (r_dice_valid && result_ready) begin
              r_state      <= ST_WAIT_CLEAR;
              r_dice_valid <= 1'b0;
              r_cnt        <= 8'd0;
              r_wcnt       <= 8'd0;
`ifdef DICE_STAB_TIMEOUT_EN
              r_tcnt       <= 8'd0;
`endif
            end
          end
          ST_WAIT_CLEAR: begin
            if (frame_done) begin
              r_wcnt <= w_is_white ? w_wcnt_inc : 8'd0;
`ifdef DICE_STAB_TIMEOUT_EN
              r_tcnt <= w_tcnt_inc;
`endif
              if (w_white_done) begin
                r_state    <= ST_ARMED;
                r_turn_end <= 1'b1;
                r_wcnt     <= 8'd0;
              end
`ifdef DICE_STAB_TIMEOUT_EN
              else if (w_tcnt_inc == LP_TIMEOUT) begin
                r_state    <= ST_ARMED;
                r_turn_end <= 1'b1;
                r_timeout  <= 1'b1;
                r_wcnt     <= 8'd0;
              end
`endif
            end
          end
          default: r_state <= ST_ARMED;
        endcase
      end
    end
  end

  assign dice_valid      = r_dice_valid;
  assign dice_color      = r_dice_color;
  assign dice_confidence = r_dice_conf;
  assign turn_end        = r_turn_end;
  assign timeout         = r_timeout;
  assign state           = r_state;

endmodule

// File: doc/dice_result_stabilizer.md
# dice_result_stabilizer

Frame-level temporal filter between the ROI color detector and the game FSM. It consumes the detector's per-frame verdict (`color_valid`, `dominant_color`, `white_detected`) and declares a dice result only after the same color has been seen for `STABLE_FRAMES` consecutive frames. It presents the result over a valid/ready handshake, then requires `WHITE_FRAMES` consecutive white-background frames before re-arming for the next turn.

## Interface
Parameters:
- `STABLE_FRAMES`, default 3: consecutive same-color frames needed to declare a result; legal range 1..255.
- `WHITE_FRAMES`, default 2: consecutive white frames needed to end the turn; legal range 1..255.
- `TIMEOUT_FRAMES`, default 120: frame limit on `WAIT_CLEAR`. Used only when `DICE_STAB_TIMEOUT_EN` is defined; legal range 1..255.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `game_enable` in 1: when low, synchronously aborts to `ARMED`.
- `frame_done` in 1: one-cycle pulse per frame, aligned with the detector's `color_valid`/`white_detected` pulse cycle.
- `color_valid` in 1: detector reports an R/G/B frame.
- `white_detected` in 1: detector reports a white frame.
- `dominant_color` in 2: 01 = red, 10 = green, 11 = blue.
- `color_confidence` in 16: detector pixel count for the frame.
- `result_ready` in 1: game FSM accepts the result.
- `dice_valid` out 1: result available; held until accepted.
- `dice_color` out 2: confirmed color code, which is also the step count (1–3).
- `dice_confidence` out 16: minimum `color_confidence` over the confirming frames.
- `turn_end` out 1: one-cycle pulse when the turn ends.
- `timeout` out 1: one-cycle pulse when `WAIT_CLEAR` times out.
- `state` out 2: 0 = `ARMED`, 1 = `CONFIRM`, 2 = `HOLD`, 3 = `WAIT_CLEAR`.

## Operation
Frame classification is sampled only in a cycle with `frame_done` = 1:
- COLOR(c): `color_valid` = 1 and `dominant_color` ≠ 00. COLOR wins if `white_detected` is also high.
- WHITE: `white_detected` = 1 and not COLOR.
- NONE: otherwise.
- `color_valid`/`white_detected` without `frame_done` are ignored.

State machine:
- `ARMED`
  - COLOR(c): `cand` = c, `cnt` = 1, `minconf` = `color_confidence`. Go to `HOLD` if `STABLE_FRAMES` = 1, else go to `CONFIRM`.
  - WHITE or NONE: stay in `ARMED`.
- `CONFIRM`
  - COLOR(`cand`): `cnt`+1; `minconf` = min(`minconf`, conf). When `cnt`+1 = `STABLE_FRAMES`, go to `HOLD`.
  - COLOR(other): restart with the new candidate (`cnt` = 1, `minconf` = conf).
  - NONE: no change (tolerated dropout).
  - WHITE: go to `ARMED`, clear `cnt`.
- `HOLD`
  - `dice_valid` = 1; `dice_color` and `dice_confidence` stay stable.
  - `frame_done` is ignored.
  - `dice_valid` & `result_ready` at a clock edge: transfer; go to `WAIT_CLEAR`, clear `wcnt`.
- `WAIT_CLEAR`
  - WHITE: `wcnt`+1. When `wcnt`+1 = `WHITE_FRAMES`, pulse `turn_end` and go to `ARMED`.
  - COLOR or NONE: `wcnt` = 0.

Other rules:
- `result_ready` outside `HOLD` is ignored.
- `game_enable` = 0 in any state: go to `ARMED` on the next edge, clear all counters, drop `dice_valid` without a handshake, no `turn_end`.
- Counters are 8-bit and saturate at 255. The min compare is unsigned 16-bit.
- `dice_color`/`dice_confidence` keep their last value after leaving `HOLD` and are 0 after reset.

## Timing
- Reset values: `state` = `ARMED`; every output = 0.
- All outputs are registered.
- `dice_valid` rises the cycle after the `frame_done` that completes confirmation.
- Latency from the first frame of a color to `dice_valid` is `STABLE_FRAMES` frames plus 1 clock.
- `dice_valid` falls the cycle after the accepting edge.
- `turn_end` is high for exactly the one cycle after the final WHITE `frame_done`; `state` reads `ARMED` in that same cycle.
- A new COLOR frame is acted on one frame after the `ARMED` return; it cannot coincide with `turn_end`, since one `frame_done` per frame.
- `reset` mid-operation clears everything immediately (asynchronous).

## Configuration
- `DICE_STAB_TIMEOUT_EN` defined:
  - `WAIT_CLEAR` counts every `frame_done` in an 8-bit `tcnt`.
  - When `tcnt` reaches `TIMEOUT_FRAMES` without the white condition, pulse `timeout` and `turn_end` together for one cycle and go to `ARMED`.
  - If both conditions complete on the same frame, the white completion wins: `turn_end` only, no `timeout`.
- Not defined: no `tcnt`; `timeout` is tied to 0; `WAIT_CLEAR` waits indefinitely.

## Test plan
- Defaults: 3 consecutive COLOR(01) frames with confidence 900, 700, 800 -> `dice_valid` = 1, `dice_color` = 01, `dice_confidence` = 700, one clock after the 3rd `frame_done`.
- COLOR(10), COLOR(10), NONE, COLOR(10) -> result 10 after the 4th frame. COLOR(10), COLOR(11), COLOR(11), COLOR(11) -> result 11. COLOR(10), WHITE -> `state` = `ARMED`, no result.
- `HOLD` with `result_ready` = 0 for 10 frames of COLOR(01) -> `dice_valid` stays 1 and outputs stable. `result_ready` = 1 for one cycle -> `dice_valid` = 0 next cycle, `state` = 3.
- `WAIT_CLEAR`: WHITE, COLOR(01), WHITE, WHITE -> exactly one `turn_end` pulse after the 4th frame, `state` = 0.
- `game_enable` dropped in `CONFIRM` (`cnt` = 2) and in `HOLD` -> `ARMED` next edge, `dice_valid` = 0, no `turn_end`. Async `reset` mid-`HOLD` -> all outputs 0 immediately.
- With `DICE_STAB_TIMEOUT_EN` and `TIMEOUT_FRAMES` = 5: 5 NONE frames in `WAIT_CLEAR` -> `timeout` and `turn_end` high together for 1 cycle. Without the macro: 300 NONE frames leave `state` = 3 and `timeout` = 0.
